// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: issues pipelined word reads under a credit limit and
// buffers returned words with their PCs in a first-word-fall-through queue for decode.
module rv_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic        im_busy_i,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_pc_bra_i,
  output logic        f_valid_o,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  input  logic        d_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   req_pc, rsp_pc;
  logic [CW-1:0] count, inflight, drop, inflight_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW:0]   occupancy;
  logic [31:0]   target;
  logic          accept, push, pop;

  logic [31:0] ir_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];

  assign target    = x_pc_bra_i & ~32'h3;
  assign occupancy = (CW+1)'(count) + (CW+1)'(inflight);

  // Gating with rst_i keeps the request low for the whole reset window, not just after an edge.
  assign im_rd_o   = !rst_i && !x_bra_i && (occupancy < (CW+1)'(DEPTH));
  assign im_addr_o = req_pc;
  assign accept    = im_rd_o && !im_busy_i;
  assign push      = im_valid_i && (drop == '0) && !x_bra_i;
  assign pop       = f_valid_o && d_ready_i && !x_bra_i;

  assign f_valid_o = (count != '0);
  assign f_ir_o    = f_valid_o ? ir_mem[rd_ptr] : '0;
  assign f_pc_o    = f_valid_o ? pc_mem[rd_ptr] : '0;

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !im_valid_i)
      inflight_nxt = inflight + CW'(1);
    else if (!accept && im_valid_i)
      inflight_nxt = inflight - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (x_bra_i) begin
        // Everything still in flight belongs to the old stream and must be discarded.
        req_pc <= target;
        rsp_pc <= target;
        drop   <= inflight_nxt;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept)
          req_pc <= req_pc + 32'd4;
        if (im_valid_i && (drop != '0))
          drop <= drop - CW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (!push && pop)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ir_mem[wr_ptr] <= im_data_i;
      pc_mem[wr_ptr] <= rsp_pc;
    end
  end

endmodule
